// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encodings and the
// oversample divider calculation used by the tick generator.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Clamped to 1 so very low clock/baud ratios still produce a tick.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    int d;
    d = clk_freq / (baud_rate * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_if.sv
// UART user-side bundle: byte-level TX request, RX result, serial pins and
// FSM state visibility.
interface uart_if;
  import uart_pkg::*;

  logic       rx;
  logic       rx_en;
  logic       rx_valid;
  logic [7:0] rx_out;
  logic [7:0] tx_in;
  logic       tx_en;
  logic       tx;
  logic       tx_busy;
  tx_state_t  tx_state;
  rx_state_t  rx_state;

  // Handshake: a TX request is accepted on a clock edge where tx_en=1 and
  // tx_busy=0; tx_in is sampled only on that edge. rx_valid is a one-cycle
  // strobe with no back-pressure; rx_out stays stable until the next strobe.
  modport master (
    output rx, rx_en, tx_in, tx_en,
    input  rx_valid, rx_out, tx, tx_busy, tx_state, rx_state
  );

  modport slave (
    input  rx, rx_en, tx_in, tx_en,
    output rx_valid, rx_out, tx, tx_busy, tx_state, rx_state
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick: one clk-wide pulse every
// CLK_FREQ/(BAUD_RATE*16) cycles, shared by transmitter and receiver.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (cnt == CW'(DIV-1))  cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CW'(DIV-1));

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: independent TX and RX state machines driven by a
// shared 16x oversample tick; RX samples each bit once at mid-bit.
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  uart_if.slave bus
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t  tx_state, tx_state_nxt;
  logic [3:0] tx_tcnt, tx_tcnt_nxt;
  logic [2:0] tx_bit, tx_bit_nxt;
  logic [7:0] tx_shreg, tx_shreg_nxt;
  logic       tx_bit_end;

  assign tx_bit_end = tick && (tx_tcnt == LAST_TICK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_tcnt  <= tx_tcnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shreg <= tx_shreg_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tcnt_nxt  = tick ? tx_tcnt + 4'd1 : tx_tcnt;
    tx_bit_nxt   = tx_bit;
    tx_shreg_nxt = tx_shreg;
    case (tx_state)
      TX_IDLE: begin
        tx_tcnt_nxt = '0;
        tx_bit_nxt  = '0;
        if (bus.tx_en) begin
          tx_shreg_nxt = bus.tx_in;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: if (tx_bit_end) tx_state_nxt = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_shreg_nxt = {1'b0, tx_shreg[7:1]};
        tx_bit_nxt   = tx_bit + 3'd1;
        if (tx_bit == LAST_BIT) tx_state_nxt = TX_STOP;
      end
      TX_STOP: if (tx_bit_end) tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Line and busy decode from the same state so they change on one edge.
  assign bus.tx       = (tx_state == TX_START) ? 1'b0 :
                        (tx_state == TX_DATA)  ? tx_shreg[0] : 1'b1;
  assign bus.tx_busy  = (tx_state != TX_IDLE);
  assign bus.tx_state = tx_state;

  // ---------------- receiver ----------------
  logic       rx_s1, rx_s2;
  rx_state_t  rx_state, rx_state_nxt;
  logic [3:0] rx_tcnt, rx_tcnt_nxt;
  logic [2:0] rx_bit, rx_bit_nxt;
  logic [7:0] rx_shreg, rx_shreg_nxt;
  logic [7:0] rx_out_q, rx_out_nxt;
  logic       rx_valid_q, rx_valid_nxt;
  logic       rx_bit_mid;

  assign rx_bit_mid = tick && (rx_tcnt == LAST_TICK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_tcnt    <= '0;
      rx_bit     <= '0;
      rx_shreg   <= '0;
      rx_out_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_s1      <= bus.rx;
      rx_s2      <= rx_s1;
      rx_state   <= rx_state_nxt;
      rx_tcnt    <= rx_tcnt_nxt;
      rx_bit     <= rx_bit_nxt;
      rx_shreg   <= rx_shreg_nxt;
      rx_out_q   <= rx_out_nxt;
      rx_valid_q <= rx_valid_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tcnt_nxt  = tick ? rx_tcnt + 4'd1 : rx_tcnt;
    rx_bit_nxt   = rx_bit;
    rx_shreg_nxt = rx_shreg;
    rx_out_nxt   = rx_out_q;
    rx_valid_nxt = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_tcnt_nxt = '0;
        rx_bit_nxt  = '0;
        if (bus.rx_en && !rx_s2) rx_state_nxt = RX_START;
      end
      // Half a bit in: a high line here means the falling edge was noise.
      RX_START: if (tick && rx_tcnt == MID_TICK) begin
        rx_tcnt_nxt  = '0;
        rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_mid) begin
        rx_shreg_nxt = {rx_s2, rx_shreg[7:1]};
        rx_bit_nxt   = rx_bit + 3'd1;
        if (rx_bit == LAST_BIT) rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (rx_bit_mid) begin
        if (rx_s2) begin
          rx_out_nxt   = rx_shreg;
          rx_valid_nxt = 1'b1;
        end
        rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  assign bus.rx_out   = rx_out_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_state = rx_state;

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart at a reduced clock/baud ratio (2 clocks per tick,
// 32 clocks per bit) so every frame scenario fits in a few thousand cycles.
module tb_uart;
  import uart_pkg::*;

  localparam int BIT_CYC = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_if u_if ();

  uart #(.CLK_FREQ(320), .BAUD_RATE(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  int total = 0;
  int bad = 0;
  int vcount = 0;
  int wide_pulses = 0;
  int v0;
  logic [7:0] last_byte = 8'h00;
  logic prev_valid = 1'b0;

  // rx_valid monitor: counts strobes and flags any strobe longer than a cycle.
  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      vcount++;
      last_byte = u_if.rx_out;
      if (prev_valid) wide_pulses++;
    end
    prev_valid = u_if.rx_valid;
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame on rx starting at a negedge; stop bit length adjustable.
  task automatic send_rx(input logic [7:0] data, input logic stop_bit, input int stop_cyc);
    logic [9:0] f;
    f = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      u_if.rx = f[i];
      repeat ((i == 9) ? stop_cyc : BIT_CYC) @(negedge clk);
    end
    u_if.rx = 1'b1;
  endtask

  // Waits for a start bit on tx, then samples every bit at its middle.
  task automatic expect_tx(input logic [7:0] data, input string tag);
    logic [9:0] f;
    int waited;
    f = {1'b1, data, 1'b0};
    waited = 0;
    while (u_if.tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check(32'(waited < 400), 1, {tag, " start_seen"});
    check(u_if.tx_busy, 1, {tag, " busy_at_start"});
    repeat (BIT_CYC / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check(u_if.tx, f[i], $sformatf("%s bit%0d", tag, i));
      check(u_if.tx_busy, 1, $sformatf("%s busy%0d", tag, i));
      if (i < 9) repeat (BIT_CYC) @(negedge clk);
    end
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.rx = 1'b1; u_if.rx_en = 1'b0; u_if.tx_in = 8'h00; u_if.tx_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check(u_if.tx, 1, "rst tx");
    check(u_if.tx_busy, 0, "rst tx_busy");
    check(u_if.rx_valid, 0, "rst rx_valid");
    check(u_if.rx_out, 8'h00, "rst rx_out");
    check(u_if.tx_state, TX_IDLE, "rst tx_state");
    check(u_if.rx_state, RX_IDLE, "rst rx_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single TX frame 0x9E, request held for one bit time
    u_if.tx_in = 8'h9E; u_if.tx_en = 1'b1;
    fork
      expect_tx(8'h9E, "tx_9e");
      begin repeat (BIT_CYC) @(negedge clk); u_if.tx_en = 1'b0; u_if.tx_in = 8'h00; end
    join
    repeat (BIT_CYC) @(negedge clk);
    check(u_if.tx_busy, 0, "tx_9e busy_after");
    check(u_if.tx, 1, "tx_9e idle_line");

    // RX frame 0x9E
    u_if.rx_en = 1'b1;
    v0 = vcount;
    send_rx(8'h9E, 1'b1, BIT_CYC);
    repeat (4) @(negedge clk);
    check(vcount, v0 + 1, "rx_9e strobes");
    check(last_byte, 8'h9E, "rx_9e byte_at_strobe");
    check(u_if.rx_out, 8'h9E, "rx_9e rx_out");

    // Framing error: stop bit held low through its sampling point only
    v0 = vcount;
    send_rx(8'h55, 1'b0, 20);
    repeat (2 * BIT_CYC) @(negedge clk);
    check(vcount, v0, "rx_ferr no_strobe");
    check(u_if.rx_out, 8'h9E, "rx_ferr rx_out_held");
    check(u_if.rx_state, RX_IDLE, "rx_ferr idle");

    // Four-tick glitch rejected, then a clean frame
    v0 = vcount;
    u_if.rx = 1'b0;
    repeat (8) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    check(u_if.rx_state, RX_IDLE, "glitch idle");
    check(vcount, v0, "glitch no_strobe");
    send_rx(8'hA5, 1'b1, BIT_CYC);
    repeat (4) @(negedge clk);
    check(vcount, v0 + 1, "rx_a5 strobes");
    check(u_if.rx_out, 8'hA5, "rx_a5 rx_out");

    // Receiver disabled: frame ignored
    u_if.rx_en = 1'b0;
    v0 = vcount;
    send_rx(8'h3C, 1'b1, BIT_CYC);
    repeat (4) @(negedge clk);
    check(vcount, v0, "rx_dis no_strobe");
    check(u_if.rx_out, 8'hA5, "rx_dis rx_out_held");

    // rx_en dropped mid-frame does not abort it
    u_if.rx_en = 1'b1;
    v0 = vcount;
    fork
      send_rx(8'h5A, 1'b1, BIT_CYC);
      begin repeat (3 * BIT_CYC) @(negedge clk); u_if.rx_en = 1'b0; end
    join
    repeat (4) @(negedge clk);
    check(vcount, v0 + 1, "rx_en_drop strobes");
    check(u_if.rx_out, 8'h5A, "rx_en_drop rx_out");
    u_if.rx_en = 1'b1;

    // Back-to-back TX; tx_in change during the first frame must not leak in
    u_if.tx_in = 8'h01; u_if.tx_en = 1'b1;
    fork
      expect_tx(8'h01, "b2b_first");
      begin repeat (4 * BIT_CYC) @(negedge clk); u_if.tx_in = 8'h80; end
    join
    fork
      expect_tx(8'h80, "b2b_second");
      begin repeat (4 * BIT_CYC) @(negedge clk); u_if.tx_en = 1'b0; end
    join
    repeat (BIT_CYC) @(negedge clk);
    check(u_if.tx_busy, 0, "b2b busy_after");
    check(u_if.tx, 1, "b2b idle_line");

    // Reset in the middle of a TX frame and an RX frame
    v0 = vcount;
    u_if.tx_in = 8'hF0; u_if.tx_en = 1'b1; u_if.rx = 1'b0;
    repeat (2) @(negedge clk);
    u_if.tx_en = 1'b0;
    repeat (3 * BIT_CYC - 2) @(negedge clk);
    check(u_if.tx_busy, 1, "midrst tx_active");
    check(u_if.rx_state, RX_DATA, "midrst rx_active");
    reset = 1'b0;
    #1;
    check(u_if.tx, 1, "midrst tx");
    check(u_if.tx_busy, 0, "midrst tx_busy");
    check(u_if.rx_valid, 0, "midrst rx_valid");
    check(u_if.rx_out, 8'h00, "midrst rx_out");
    check(u_if.tx_state, TX_IDLE, "midrst tx_state");
    check(u_if.rx_state, RX_IDLE, "midrst rx_state");
    u_if.rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check(vcount, v0, "midrst no_strobe");

    // Full duplex after reset
    v0 = vcount;
    u_if.tx_in = 8'h3C; u_if.tx_en = 1'b1;
    fork
      expect_tx(8'h3C, "duplex_tx");
      begin repeat (BIT_CYC) @(negedge clk); u_if.tx_en = 1'b0; end
      send_rx(8'hC3, 1'b1, BIT_CYC);
    join
    repeat (4) @(negedge clk);
    check(vcount, v0 + 1, "duplex_rx strobes");
    check(u_if.rx_out, 8'hC3, "duplex_rx rx_out");
    check(wide_pulses, 0, "rx_valid width");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in baud.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  serial receive line, idle high, asynchronous to clk.
REQ-006 rx_en  input  1  receiver enable (level).
REQ-007 rx_valid  output  1  one-cycle strobe: rx_out holds a new valid byte.
REQ-008 rx_out  output  8  last received byte.
REQ-009 tx_in  input  8  byte to transmit.
REQ-010 tx_en  input  1  transmit request (level).
REQ-011 tx  output  1  serial transmit line, idle high.
REQ-012 tx_busy  output  1  high while a transmit frame is in progress.

Function
REQ-013 Frame format SHALL be 8N1: start 0, 8 data bits LSB first, 1 stop bit of 1.
REQ-014 Oversample tick SHALL be one clk pulse every BAUD_DIV = CLK_FREQ/(BAUD_RATE*16) cycles (integer division; 325 at defaults); one bit = 16 ticks.
REQ-015 TX FSM states IDLE, START, DATA, STOP; each non-IDLE bit SHALL last exactly 16 ticks.
REQ-016 In IDLE with tx_en=1 at a clock edge, tx_in SHALL be latched and the FSM SHALL enter START on the next edge; tx_busy SHALL rise in the same cycle tx falls for START.
REQ-017 tx_busy SHALL stay high through START, DATA and STOP and drop on return to IDLE; tx_in/tx_en changes while busy SHALL be ignored.
REQ-018 If tx_en is still high on return to IDLE, a new frame SHALL start (back-to-back); tx SHALL be high in IDLE.
REQ-019 rx SHALL pass a 2-flop synchronizer before any use.
REQ-020 RX FSM states IDLE, START, DATA, STOP; IDLE SHALL leave only when rx_en=1 and synchronized rx is 0.
REQ-021 In START, rx SHALL be resampled at tick 8 (mid-bit); if 1, treat as glitch and return to IDLE.
REQ-022 Each data bit SHALL be sampled once at its mid-bit (16 ticks after previous sample) and shifted in LSB first.
REQ-023 At stop-bit mid-point: if rx=1, rx_out SHALL update with the byte and rx_valid SHALL pulse high exactly one clk; if rx=0 (framing error), the byte SHALL be discarded, no rx_valid, rx_out unchanged; FSM returns to IDLE either way.
REQ-024 rx_out SHALL hold its value until the next valid frame.
REQ-025 Deasserting rx_en mid-frame SHALL NOT abort the current frame; rx_en is checked only in IDLE.
REQ-026 TX and RX SHALL operate independently and concurrently (full duplex), sharing the tick generator.

Reset
REQ-027 Asserting reset (low) SHALL immediately force: both FSMs IDLE, tick counter 0, tx=1, tx_busy=0, rx_valid=0, rx_out=8'h00, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abort the frame with no rx_valid and no partial output.

Structure
REQ-029 Shared package uart_pkg SHALL hold the TX/RX state enum typedefs and the frame constants (DATA_BITS=8, OVERSAMPLE=16).
REQ-030 Tick generation SHALL be a sub-module uart_baud_gen (params CLK_FREQ, BAUD_RATE; output tick).

Verification
REQ-031 Reset released, tx_en=1 with tx_in=8'h9E for one bit time -> tx_busy rises; tx line shows 0,0,1,1,1,1,0,0,1,1 at 1/9600 s per bit; tx_busy falls after 10 bits.
REQ-032 rx_en=1, drive rx frame for 8'h9E (0,0,1,1,1,1,0,0,1,1) -> one-cycle rx_valid, rx_out=8'h9E.
REQ-033 rx frame 8'h55 with stop bit 0 -> no rx_valid, rx_out keeps previous 8'h9E.
REQ-034 rx low pulse of 4 ticks while idle -> RX returns to IDLE, no rx_valid; following frame 8'hA5 received correctly.
REQ-035 tx_en held high with tx_in=8'h01 then 8'h80 changed mid-frame -> first frame sends 8'h01 unaltered, second frame sends 8'h80 back-to-back.
REQ-036 reset asserted mid-TX and mid-RX frame -> tx=1, tx_busy=0, rx_valid=0 immediately; next clean frames work.
